risc16_ctrl_fsm: RTL and testbench
==================================

Name: risc16_ctrl_fsm

Overview:
- Multi-cycle control unit for the 16-bit RiSC-16 datapath; sits directly upstream of the ALU.
- Fetches an instruction word over a req/ack memory handshake and holds it in an internal IR.
- Decodes it and drives the ALU select lines (imm, mux_alu1, mux_alu2, func_alu), register-file controls, PC update and data-memory access.
- Consumes the ALU's EQ output to resolve BEQ.

Parameters:
- HALT_EN, 1: when 1, JALR with instr[6:0] != 0 enters HALT; when 0, it executes as a normal JALR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_rdata  in  16  instruction word, sampled when mem_ack=1 in FETCH.
- mem_ack  in  1  memory completion for the current mem_req.
- eq  in  1  ALU EQ result.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = store (MEM state, SW only).
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- rf_ra_addr  out  3  register read port 1 address (drives ALU src1).
- rf_rb_addr  out  3  register read port 2 address (drives ALU src2 / store data).
- rf_wr_addr  out  3  register write address.
- rf_we  out  1  register write enable.
- rf_wsel  out  2  write data select: 0 = ALU, 1 = mem data, 2 = PC+1.
- imm  out  10  IR[9:0], to the ALU.
- mux_alu1  out  2  ALU src1 select: 0 = reg, 1 = imm<<6.
- mux_alu2  out  2  ALU src2 select: 0 = reg, 1 = sign-extended imm[6:0].
- func_alu  out  2  ALU function: 00 = add, 01 = nand, 10 = pass src1.
- pc_we  out  1  PC write enable.
- pc_sel  out  2  next PC: 0 = PC+1, 1 = PC+1+simm7, 2 = port-2 register.
- halted  out  1  1 while in HALT.

Behaviour:
- Reset:
  - While rst=1, every output is 0, state <= FETCH, IR <= 0.
  - Reset asserted mid-operation aborts immediately: mem_req drops in the same cycle, and no rf_we or pc_we is issued.
- Outputs: combinational from (state, IR).
- States: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH:
  - Drive mem_req=1, mem_addr_sel=0, mem_we=0.
  - On a cycle with mem_ack=1: IR <= mem_rdata, next state DECODE.
  - Otherwise remain in FETCH, holding outputs stable.
- DECODE: one cycle; drive read addresses and ALU selects so EXEC sees settled register data.
- Read address and ALU selects by opcode (IR[15:13]):
  - 000 ADD: ra=rB, rb=rC, func 00, mux 0/0.
  - 010 NAND: ra=rB, rb=rC, func 01, mux 0/0.
  - 001 ADDI: ra=rB, func 00, mux2=1.
  - 011 LUI: mux1=1, func 10.
  - 100 SW / 101 LW: ra=rB, rb=rA, func 00, mux2=1.
  - 110 BEQ: ra=rA, rb=rB, mux 0/0.
  - 111 JALR: rb=rB.
- Field positions: rA = IR[12:10], rB = IR[9:7], rC = IR[2:0].
- EXEC:
  - ADD/ADDI/NAND/LUI: rf_we=1, wsel=0, wr=rA; pc_we=1, pc_sel=0; then FETCH.
  - BEQ: pc_we=1, pc_sel = eq ? 1 : 0; then FETCH.
  - JALR: rf_we=1, wsel=2, wr=rA; pc_we=1, pc_sel=2; then FETCH.
  - JALR with HALT_EN=1 and IR[6:0] != 0: no writes; next state HALT.
  - LW/SW: next state MEM.
- MEM:
  - ALU selects held from EXEC; mem_req=1, mem_addr_sel=1, mem_we = (opcode == SW).
  - On mem_ack: LW gives rf_we=1, wsel=1, wr=rA. Both LW and SW give pc_we=1, pc_sel=0, then FETCH.
  - Without ack: hold all outputs.
- Register r0: rf_we is forced to 0 whenever wr_addr=0.
- HALT: halted=1, all other outputs 0; exit only via rst.
- Latency (ack in the first request cycle): ALU/branch/jump ops take 3 cycles; LW/SW take 4 cycles. Each ack wait adds 1 cycle.
- Single-cycle pulses: rf_we and pc_we each pulse exactly once per instruction.
- Spurious mem_ack: ignored in DECODE, EXEC and HALT.

Decomposition:
- Package risc16_pkg:
  - Opcode constants (OP_ADD..OP_JALR).
  - State enum.
  - ALU function codes (ADD = 00, NAND = 01, PASS1 = 10).
  - mux_alu, rf_wsel and pc_sel encodings.
- Sub-module risc16_decode: combinational IR-to-control decoder (addresses, ALU selects, op class). The FSM instantiates it and gates its outputs by state.

Test Plan:
- ADD: reset, then fetch 0x0503 (ADD r1,r2,r3) with immediate ack -> DECODE then EXEC. EXEC shows ra=2, rb=3, func 00, rf_we=1, wr=1, pc_we=1, pc_sel=0. Next FETCH at cycle 3.
- LUI: fetch 0x6BFF (LUI r2,0x3FF) -> imm=0x3FF, mux_alu1=1, func 10, rf_we=1, wr=2.
- BEQ: fetch 0xC4FF (BEQ r1,r1,-1) with eq=1 -> pc_sel=1. Repeat with eq=0 -> pc_sel=0. rf_we stays 0 in both.
- SW with delayed ack: fetch 0x8E05 (SW r3,r4,5), hold mem_ack=0 for 3 cycles in MEM -> mem_req=1, mem_we=1, mem_addr_sel=1, ra=4, rb=3, mux_alu2=1 held stable. On ack, pc_we=1 and no rf_we.
- r0 write and reset abort: fetch 0x2081 (ADDI r0,r1,1) -> rf_we=0, pc_we=1. Assert rst during a subsequent MEM state -> all outputs 0 in the same cycle, FETCH on release.
- HALT: fetch 0xE001 -> HALT, halted=1, no pc_we; stays in HALT for 10 cycles with mem_ack toggling. With HALT_EN=0 the same word gives a JALR: rf_we=0 (wr=r0), pc_sel=2.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared encodings for the RiSC-16 multi-cycle control unit: opcodes, FSM states,
// op classes and the ALU / register-file / PC select codes.
package risc16_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_MEM  = 2'd1,
    CLS_BEQ  = 2'd2,
    CLS_JALR = 2'd3
  } op_class_e;

  localparam logic [1:0] FUNC_ADD   = 2'b00;
  localparam logic [1:0] FUNC_NAND  = 2'b01;
  localparam logic [1:0] FUNC_PASS1 = 2'b10;

  localparam logic [1:0] MUX1_REG  = 2'd0;
  localparam logic [1:0] MUX1_IMM  = 2'd1;
  localparam logic [1:0] MUX2_REG  = 2'd0;
  localparam logic [1:0] MUX2_SIMM = 2'd1;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_PC1 = 2'd2;

  localparam logic [1:0] PCSEL_INC = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_REG = 2'd2;

  function automatic logic [2:0] opcode(input logic [15:0] ir);
    return ir[15:13];
  endfunction

endpackage

// File: rtl/risc16_decode.sv
// Combinational IR decoder: register addresses, ALU selects and op class.
// The FSM decides in which states these are actually presented.
module risc16_decode
  import risc16_pkg::*;
#(
  parameter int HALT_EN = 1
) (
  input  logic [15:0] ir,
  output logic [2:0]  ra,
  output logic [2:0]  rb,
  output logic [2:0]  field_ra,
  output logic [9:0]  imm,
  output logic [1:0]  mux_alu1,
  output logic [1:0]  mux_alu2,
  output logic [1:0]  func_alu,
  output op_class_e   op_class,
  output logic        is_sw,
  output logic        halt_op
);

  logic [2:0] f_rb;
  logic [2:0] f_rc;

  assign field_ra = ir[12:10];
  assign f_rb     = ir[9:7];
  assign f_rc     = ir[2:0];
  assign imm      = ir[9:0];

  always_comb begin
    ra       = '0;
    rb       = '0;
    mux_alu1 = MUX1_REG;
    mux_alu2 = MUX2_REG;
    func_alu = FUNC_ADD;
    op_class = CLS_ALU;
    is_sw    = 1'b0;
    halt_op  = 1'b0;
    case (opcode(ir))
      OP_ADD: begin
        ra = f_rb;
        rb = f_rc;
      end
      OP_NAND: begin
        ra       = f_rb;
        rb       = f_rc;
        func_alu = FUNC_NAND;
      end
      OP_ADDI: begin
        ra       = f_rb;
        mux_alu2 = MUX2_SIMM;
      end
      OP_LUI: begin
        mux_alu1 = MUX1_IMM;
        func_alu = FUNC_PASS1;
      end
      OP_SW, OP_LW: begin
        // Address = rB + simm7; port 2 carries rA as store data.
        ra       = f_rb;
        rb       = field_ra;
        mux_alu2 = MUX2_SIMM;
        op_class = CLS_MEM;
        is_sw    = (opcode(ir) == OP_SW);
      end
      OP_BEQ: begin
        ra       = field_ra;
        rb       = f_rb;
        op_class = CLS_BEQ;
      end
      OP_JALR: begin
        rb       = f_rb;
        op_class = CLS_JALR;
        halt_op  = (HALT_EN != 0) && (ir[6:0] != 7'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/risc16_ctrl_fsm.sv
// Multi-cycle RiSC-16 control unit: fetch over req/ack, decode, execute, memory.
// Outputs are combinational from state and IR, and are all forced low while rst is high.
module risc16_ctrl_fsm
  import risc16_pkg::*;
#(
  parameter int HALT_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        eq,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [2:0]  rf_ra_addr,
  output logic [2:0]  rf_rb_addr,
  output logic [2:0]  rf_wr_addr,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [9:0]  imm,
  output logic [1:0]  mux_alu1,
  output logic [1:0]  mux_alu2,
  output logic [1:0]  func_alu,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        halted
);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [15:0] ir;

  logic [2:0]  dec_ra;
  logic [2:0]  dec_rb;
  logic [2:0]  dec_field_ra;
  logic [9:0]  dec_imm;
  logic [1:0]  dec_mux1;
  logic [1:0]  dec_mux2;
  logic [1:0]  dec_func;
  op_class_e   dec_class;
  logic        dec_is_sw;
  logic        dec_halt;

  logic        drive_sel;
  logic        we_raw;

  risc16_decode #(
    .HALT_EN (HALT_EN)
  ) u_decode (
    .ir       (ir),
    .ra       (dec_ra),
    .rb       (dec_rb),
    .field_ra (dec_field_ra),
    .imm      (dec_imm),
    .mux_alu1 (dec_mux1),
    .mux_alu2 (dec_mux2),
    .func_alu (dec_func),
    .op_class (dec_class),
    .is_sw    (dec_is_sw),
    .halt_op  (dec_halt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && mem_ack) begin
        ir <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:  if (mem_ack) state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        if (dec_halt)                 state_next = ST_HALT;
        else if (dec_class == CLS_MEM) state_next = ST_MEM;
        else                          state_next = ST_FETCH;
      end
      ST_MEM:    if (mem_ack) state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    rf_ra_addr   = '0;
    rf_rb_addr   = '0;
    rf_wr_addr   = '0;
    rf_we        = 1'b0;
    rf_wsel      = WSEL_ALU;
    imm          = '0;
    mux_alu1     = MUX1_REG;
    mux_alu2     = MUX2_REG;
    func_alu     = FUNC_ADD;
    pc_we        = 1'b0;
    pc_sel       = PCSEL_INC;
    halted       = 1'b0;
    we_raw       = 1'b0;
    drive_sel    = (state == ST_DECODE) || (state == ST_EXEC) || (state == ST_MEM);

    if (drive_sel) begin
      rf_ra_addr = dec_ra;
      rf_rb_addr = dec_rb;
      imm        = dec_imm;
      mux_alu1   = dec_mux1;
      mux_alu2   = dec_mux2;
      func_alu   = dec_func;
    end

    case (state)
      ST_FETCH: mem_req = 1'b1;
      ST_EXEC: begin
        case (dec_class)
          CLS_ALU: begin
            we_raw     = 1'b1;
            rf_wsel    = WSEL_ALU;
            rf_wr_addr = dec_field_ra;
            pc_we      = 1'b1;
            pc_sel     = PCSEL_INC;
          end
          CLS_BEQ: begin
            pc_we  = 1'b1;
            pc_sel = eq ? PCSEL_BR : PCSEL_INC;
          end
          CLS_JALR: begin
            if (!dec_halt) begin
              we_raw     = 1'b1;
              rf_wsel    = WSEL_PC1;
              rf_wr_addr = dec_field_ra;
              pc_we      = 1'b1;
              pc_sel     = PCSEL_REG;
            end
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_is_sw;
        if (mem_ack) begin
          if (!dec_is_sw) begin
            we_raw     = 1'b1;
            rf_wsel    = WSEL_MEM;
            rf_wr_addr = dec_field_ra;
          end
          pc_we  = 1'b1;
          pc_sel = PCSEL_INC;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase

    // r0 is hardwired to zero, so a write to it is suppressed here.
    rf_we = we_raw && (rf_wr_addr != 3'd0);

    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      rf_ra_addr   = '0;
      rf_rb_addr   = '0;
      rf_wr_addr   = '0;
      rf_we        = 1'b0;
      rf_wsel      = '0;
      imm          = '0;
      mux_alu1     = '0;
      mux_alu2     = '0;
      func_alu     = '0;
      pc_we        = 1'b0;
      pc_sel       = '0;
      halted       = 1'b0;
    end
  end

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// Scoreboard bench for risc16_ctrl_fsm: per-cycle stimulus and expected outputs are
// queued by each scenario task, then popped and compared against the DUT.
module tb_risc16_ctrl_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wr;
    logic       rf_we;
    logic [1:0] wsel;
    logic [9:0] imm;
    logic [1:0] mux1;
    logic [1:0] mux2;
    logic [1:0] func;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       halted;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic        eq;
    logic [15:0] rdata;
    logic        chk1;
    out_t        exp;
    out_t        exp1;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        eq;

  logic        mem_req, mem_we, mem_addr_sel, rf_we, pc_we, halted;
  logic [2:0]  rf_ra_addr, rf_rb_addr, rf_wr_addr;
  logic [1:0]  rf_wsel, mux_alu1, mux_alu2, func_alu, pc_sel;
  logic [9:0]  imm;

  logic        mem_req1, mem_we1, mem_addr_sel1, rf_we1, pc_we1, halted1;
  logic [2:0]  rf_ra_addr1, rf_rb_addr1, rf_wr_addr1;
  logic [1:0]  rf_wsel1, mux_alu11, mux_alu21, func_alu1, pc_sel1;
  logic [9:0]  imm1;

  out_t  obs, obs1;
  stim_t q[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  risc16_ctrl_fsm #(.HALT_EN(1)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .eq(eq),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .rf_wr_addr(rf_wr_addr),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .imm(imm), .mux_alu1(mux_alu1),
    .mux_alu2(mux_alu2), .func_alu(func_alu), .pc_we(pc_we), .pc_sel(pc_sel),
    .halted(halted)
  );

  risc16_ctrl_fsm #(.HALT_EN(0)) dut_nohalt (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .eq(eq),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr_sel(mem_addr_sel1),
    .rf_ra_addr(rf_ra_addr1), .rf_rb_addr(rf_rb_addr1), .rf_wr_addr(rf_wr_addr1),
    .rf_we(rf_we1), .rf_wsel(rf_wsel1), .imm(imm1), .mux_alu1(mux_alu11),
    .mux_alu2(mux_alu21), .func_alu(func_alu1), .pc_we(pc_we1), .pc_sel(pc_sel1),
    .halted(halted1)
  );

  always_comb begin
    obs = '{mem_req, mem_we, mem_addr_sel, rf_ra_addr, rf_rb_addr, rf_wr_addr,
            rf_we, rf_wsel, imm, mux_alu1, mux_alu2, func_alu, pc_we, pc_sel, halted};
    obs1 = '{mem_req1, mem_we1, mem_addr_sel1, rf_ra_addr1, rf_rb_addr1, rf_wr_addr1,
             rf_we1, rf_wsel1, imm1, mux_alu11, mux_alu21, func_alu1, pc_we1, pc_sel1, halted1};
  end

  function automatic stim_t mk(logic r, logic a, logic e, logic [15:0] d, out_t x);
    stim_t s;
    s = '0;
    s.rst = r; s.ack = a; s.eq = e; s.rdata = d; s.exp = x;
    return s;
  endfunction

  function automatic out_t o_fetch();
    out_t o;
    o = '0;
    o.mem_req = 1'b1;
    return o;
  endfunction

  function automatic out_t o_sel(logic [2:0] ra, logic [2:0] rb, logic [9:0] im,
                                 logic [1:0] m1, logic [1:0] m2, logic [1:0] f);
    out_t o;
    o = '0;
    o.ra = ra; o.rb = rb; o.imm = im; o.mux1 = m1; o.mux2 = m2; o.func = f;
    return o;
  endfunction

  task automatic test_reset();
    stim_t s;
    int n = 0;
    q.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, '0));
    q.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0503, '0));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, o_fetch()));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, o_fetch()));
    while (q.size() > 0) begin
      s = q.pop_front();
      rst = s.rst; mem_ack = s.ack; eq = s.eq; mem_rdata = s.rdata;
      #2;
      if (obs !== s.exp) begin
        $display("FAIL reset[%0d] got=%h want=%h", n, obs, s.exp);
        errors++;
      end
      checks++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    stim_t s;
    out_t  e;
    int n = 0;
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0503, o_fetch()));
    e = o_sel(3'd2, 3'd3, 10'h103, 2'd0, 2'd0, 2'b00);
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'hFFFF, e));
    e.wr = 3'd1; e.rf_we = 1'b1; e.pc_we = 1'b1;
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'hFFFF, e));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, o_fetch()));
    while (q.size() > 0) begin
      s = q.pop_front();
      rst = s.rst; mem_ack = s.ack; eq = s.eq; mem_rdata = s.rdata;
      #2;
      if (obs !== s.exp) begin
        $display("FAIL add[%0d] got=%h want=%h", n, obs, s.exp);
        errors++;
      end
      checks++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lui();
    stim_t s;
    out_t  e;
    int n = 0;
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h6BFF, o_fetch()));
    e = o_sel(3'd0, 3'd0, 10'h3FF, 2'd1, 2'd0, 2'b10);
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    e.wr = 3'd2; e.rf_we = 1'b1; e.pc_we = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    while (q.size() > 0) begin
      s = q.pop_front();
      rst = s.rst; mem_ack = s.ack; eq = s.eq; mem_rdata = s.rdata;
      #2;
      if (obs !== s.exp) begin
        $display("FAIL lui[%0d] got=%h want=%h", n, obs, s.exp);
        errors++;
      end
      checks++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    stim_t s;
    out_t  e;
    int n = 0;
    for (int k = 1; k >= 0; k--) begin
      q.push_back(mk(1'b0, 1'b1, (k == 0), 16'hC4FF, o_fetch()));
      e = o_sel(3'd1, 3'd1, 10'h0FF, 2'd0, 2'd0, 2'b00);
      q.push_back(mk(1'b0, 1'b0, (k == 0), 16'h0000, e));
      e.pc_we = 1'b1; e.pc_sel = (k == 1) ? 2'd1 : 2'd0;
      q.push_back(mk(1'b0, 1'b0, (k == 1), 16'h0000, e));
    end
    while (q.size() > 0) begin
      s = q.pop_front();
      rst = s.rst; mem_ack = s.ack; eq = s.eq; mem_rdata = s.rdata;
      #2;
      if (obs !== s.exp) begin
        $display("FAIL beq[%0d] got=%h want=%h", n, obs, s.exp);
        errors++;
      end
      checks++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_delay();
    stim_t s;
    out_t  e;
    int n = 0;
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h8E05, o_fetch()));
    e = o_sel(3'd4, 3'd3, 10'h205, 2'd0, 2'd1, 2'b00);
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1;
    for (int k = 0; k < 3; k++) q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    e.pc_we = 1'b1;
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, e));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, o_fetch()));
    while (q.size() > 0) begin
      s = q.pop_front();
      rst = s.rst; mem_ack = s.ack; eq = s.eq; mem_rdata = s.rdata;
      #2;
      if (obs !== s.exp) begin
        $display("FAIL sw_delay[%0d] got=%h want=%h", n, obs, s.exp);
        errors++;
      end
      checks++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    stim_t s;
    out_t  e;
    int n = 0;
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'hB503, o_fetch()));
    e = o_sel(3'd2, 3'd5, 10'h103, 2'd0, 2'd1, 2'b00);
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
    e.rf_we = 1'b1; e.wsel = 2'd1; e.wr = 3'd5; e.pc_we = 1'b1;
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, e));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, o_fetch()));
    while (q.size() > 0) begin
      s = q.pop_front();
      rst = s.rst; mem_ack = s.ack; eq = s.eq; mem_rdata = s.rdata;
      #2;
      if (obs !== s.exp) begin
        $display("FAIL lw[%0d] got=%h want=%h", n, obs, s.exp);
        errors++;
      end
      checks++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_r0_abort();
    stim_t s;
    out_t  e;
    int n = 0;
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h2081, o_fetch()));
    e = o_sel(3'd1, 3'd0, 10'h081, 2'd0, 2'd1, 2'b00);
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    e.pc_we = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'hB503, o_fetch()));
    e = o_sel(3'd2, 3'd5, 10'h103, 2'd0, 2'd1, 2'b00);
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, e));
    q.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, '0));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, o_fetch()));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, o_fetch()));
    while (q.size() > 0) begin
      s = q.pop_front();
      rst = s.rst; mem_ack = s.ack; eq = s.eq; mem_rdata = s.rdata;
      #2;
      if (obs !== s.exp) begin
        $display("FAIL r0_abort[%0d] got=%h want=%h", n, obs, s.exp);
        errors++;
      end
      checks++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    stim_t s;
    out_t  e, e1, h;
    int n = 0;
    s = mk(1'b0, 1'b1, 1'b0, 16'hE001, o_fetch());
    s.chk1 = 1'b1; s.exp1 = o_fetch();
    q.push_back(s);
    e = o_sel(3'd0, 3'd0, 10'h001, 2'd0, 2'd0, 2'b00);
    s = mk(1'b0, 1'b0, 1'b0, 16'h0000, e);
    s.chk1 = 1'b1; s.exp1 = e;
    q.push_back(s);
    e1 = e; e1.wsel = 2'd2; e1.pc_we = 1'b1; e1.pc_sel = 2'd2;
    s = mk(1'b0, 1'b0, 1'b0, 16'h0000, e);
    s.chk1 = 1'b1; s.exp1 = e1;
    q.push_back(s);
    h = '0; h.halted = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s = mk(1'b0, (k % 2 == 1), 1'b0, 16'hE001, h);
      if (k == 0) begin
        s.chk1 = 1'b1; s.exp1 = o_fetch();
      end
      q.push_back(s);
    end
    q.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, '0));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, o_fetch()));
    while (q.size() > 0) begin
      s = q.pop_front();
      rst = s.rst; mem_ack = s.ack; eq = s.eq; mem_rdata = s.rdata;
      #2;
      if (obs !== s.exp) begin
        $display("FAIL halt[%0d] got=%h want=%h", n, obs, s.exp);
        errors++;
      end
      checks++;
      if (s.chk1) begin
        if (obs1 !== s.exp1) begin
          $display("FAIL jalr_nohalt[%0d] got=%h want=%h", n, obs1, s.exp1);
          errors++;
        end
        checks++;
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    eq = 1'b0;
    mem_rdata = 16'h0000;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_lui();
    test_beq();
    test_sw_delay();
    test_lw();
    test_r0_abort();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

endmodule
